fb_mem_arbiter: RTL and testbench
=================================

// Module: fb_mem_arbiter
// PURPOSE
// - Owns the single port of the 64x48x4bpp framebuffer memory. Shares it between three users:
//   the video pixel fetcher (vid_*), a host pixel-write port (wr_*) and a built-in clear-screen engine (clr_*).
// - Video reads always win, with zero latency; the other users fill the remaining cycles.
// - Sits between the pixel fetcher and the memory macro, in the clk_25 domain.
// PARAMETERS
// - FB_WORDS  384  words in the framebuffer (48 rows x 8 words/row; 8 pixels per word)
// - ADDR_W    9    word address width
// - PIX_W     4    bits per pixel
// - SEL_W     3    pixel-in-word select width
// PORTS
// - clk_25       in   1       pixel clock; only clock of the block
// - rst          in   1       synchronous, active-high reset
// - vid_req      in   1       fetcher read strobe (its mem_read); must be served the same cycle
// - vid_addr     in   ADDR_W  fetcher word address
// - vid_sel      in   SEL_W   fetcher pixel select
// - vid_pixel    out  PIX_W   = mem_rdata, passed through combinationally
// - wr_valid     in   1       host write request
// - wr_ready     out  1       host write accepted this cycle when wr_valid && wr_ready
// - wr_addr      in   ADDR_W  host word address
// - wr_sel       in   SEL_W   host pixel select
// - wr_data      in   PIX_W   host pixel value
// - wr_err       out  1       1-cycle pulse: accepted write had wr_addr >= FB_WORDS; write dropped
// - clr_start    in   1       pulse: fill the whole framebuffer with clr_colour
// - clr_colour   in   PIX_W   fill colour, sampled on the accepted clr_start
// - clr_busy     out  1       clear engine running
// - clr_done     out  1       1-cycle pulse after the last clear word is written
// - mem_en       out  1       memory access this cycle
// - mem_we       out  1       write (0 = read)
// - mem_wall     out  1       write all 8 nibbles of the word (clear); else only nibble mem_sel
// - mem_addr     out  ADDR_W  memory word address
// - mem_sel      out  SEL_W   memory pixel select
// - mem_wdata    out  PIX_W   write pixel (replicated across the word when mem_wall)
// - mem_rdata    in   PIX_W   read pixel, valid in the same cycle (memory runs ~5x faster)
// BEHAVIOUR
// - Reset values: wr_ready=0, wr_err=0, clr_busy=0, clr_done=0.
//   mem_en/mem_we/mem_wall=0; mem_addr/mem_sel/mem_wdata=0; state=S_IDLE; clear counter=0.
// - FSM states:
//   - S_IDLE: clr_start -> S_CLEAR. clr_start has priority over wr_valid in the same cycle.
//   - S_CLEAR: after word FB_WORDS-1 is written -> S_DONE.
//   - S_DONE: one cycle; clr_done=1; -> S_IDLE.
// - Per-cycle port priority: vid_req > clear engine > host write.
// - Video access: when vid_req=1, the memory bus carries the video read combinationally (mem_en=1, mem_we=0).
//   No register is in this path. Clear and host-write are stalled for that cycle.
// - Host write:
//   - wr_ready = (state==S_IDLE) && !vid_req && !clr_start && !rst.
//   - Accepted write drives mem_we=1, mem_wall=0 in the same cycle. Latency 0; one write per cycle max.
//   - If wr_addr >= FB_WORDS: mem_en stays 0, and wr_err pulses on the next cycle.
// - Clear engine:
//   - Counter runs 0..FB_WORDS-1. It advances only on cycles it owns the bus (mem_we=1, mem_wall=1).
//   - clr_busy=1 in S_CLEAR and S_DONE.
//   - clr_start while clr_busy is ignored.
// - Idle bus: when no access is granted, mem_en=0 and the address/data outputs are 0.
// - Synchronous rst mid-clear: abort the clear; memory is left partially filled and clr_done does not pulse.
// - vid_req held continuously: the clear and host write stall with no timeout; the counter holds its value.
// CONFIGURATION
// - FB_WR_COALESCE_EN defined:
//   - A 1-entry write buffer sits on the host port. wr_ready=1 whenever the buffer is empty or draining this cycle.
//   - A buffered write retires on the next cycle not taken by video or clear.
//   - A host write to the buffered addr/sel overwrites the buffer in place (no memory access).
//   - rst clears the buffer.
// - FB_WR_COALESCE_EN undefined: the host port is unbuffered, as described above.
// STRUCTURE
// - Package fb_pkg: FB_WORDS, ADDR_W, PIX_W, SEL_W; typedef enum arb_state_t {S_IDLE,S_CLEAR,S_DONE};
//   typedef enum grant_t {G_NONE,G_VID,G_CLR,G_WR}.
// - Sub-module fb_clear_seq: word counter, start/advance/last/done logic. The arbiter holds the FSM and grant mux.
// TESTING
// - Idle, no requests -> mem_en=0, wr_ready=1 (coalesce off).
// - vid_req=1, vid_addr=9'd17, vid_sel=3, mem_rdata=4'hA -> mem_addr=17, mem_sel=3, mem_we=0, vid_pixel=4'hA in the same cycle.
// - wr_valid with wr_addr=5, sel=2, data=4'h7 while vid_req=1 -> wr_ready=0;
//   next cycle vid_req=0 -> mem_we=1, mem_wall=0, addr=5, wdata=4'h7.
// - clr_start, colour 4'h3, vid_req every 10th cycle -> exactly 384 write cycles, addr 0..383 in order;
//   clr_done 1 cycle after the addr-383 write; no host write accepted meanwhile.
// - wr_addr=9'd400, valid -> no memory write; wr_err=1 for one cycle.
// - rst at clear word 100 -> clr_busy=0 next cycle, no clr_done; new clr_start restarts at addr 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and types for the 64x48x4bpp framebuffer memory arbiter.
package fb_pkg;

    localparam int FB_WORDS = 384;
    localparam int ADDR_W   = 9;
    localparam int PIX_W    = 4;
    localparam int SEL_W    = 3;

    localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_WORDS);
    localparam logic [ADDR_W-1:0] FB_LAST  = ADDR_W'(FB_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} arb_state_t;
    typedef enum logic [1:0] {G_NONE, G_VID, G_CLR, G_WR} grant_t;

endpackage

// File: rtl/fb_clear_seq.sv
// Clear-screen word sequencer: walks word addresses 0..FB_WORDS-1, stepping only
// on cycles where the arbiter grants it the memory bus.
module fb_clear_seq
    import fb_pkg::*;
(
    input  logic              clk_25,
    input  logic              rst,
    input  logic              start,
    input  logic              advance,
    input  logic [PIX_W-1:0]  colour,
    output logic [ADDR_W-1:0] word_addr,
    output logic [PIX_W-1:0]  fill_colour,
    output logic              last
);

    // The counter wraps to 0 after the final word so a later clear starts cleanly.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            word_addr   <= '0;
            fill_colour <= '0;
        end else if (start) begin
            word_addr   <= '0;
            fill_colour <= colour;
        end else if (advance) begin
            word_addr <= last ? '0 : word_addr + ADDR_W'(1);
        end
    end

    assign last = advance && (word_addr == FB_LAST);

endmodule

// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer arbiter: video read > clear engine > host write.
// Optional 1-entry coalescing host write buffer under `define FB_WR_COALESCE_EN.
module fb_mem_arbiter
    import fb_pkg::*;
(
    input  logic              clk_25,
    input  logic              rst,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic [SEL_W-1:0]  vid_sel,
    output logic [PIX_W-1:0]  vid_pixel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_err,
    input  logic              clr_start,
    input  logic [PIX_W-1:0]  clr_colour,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_wall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [SEL_W-1:0]  mem_sel,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata
);

    arb_state_t        state, state_next;
    grant_t            grant;
    logic              clr_accept, clr_last;
    logic [ADDR_W-1:0] clr_addr;
    logic [PIX_W-1:0]  clr_fill;
    logic              wr_accept, wr_in_range, wr_pending;
    logic [ADDR_W-1:0] wr_mem_addr;
    logic [SEL_W-1:0]  wr_mem_sel;
    logic [PIX_W-1:0]  wr_mem_data;

    assign vid_pixel   = mem_rdata;
    assign clr_accept  = !rst && (state == S_IDLE) && clr_start;
    assign clr_busy    = (state == S_CLEAR) || (state == S_DONE);
    assign clr_done    = (state == S_DONE);
    assign wr_accept   = wr_valid && wr_ready;
    assign wr_in_range = (wr_addr < FB_LIMIT);

`ifdef FB_WR_COALESCE_EN
    logic              buf_valid, buf_hit, buf_drain;
    logic [ADDR_W-1:0] buf_addr;
    logic [SEL_W-1:0]  buf_sel;
    logic [PIX_W-1:0]  buf_data;

    assign buf_drain   = (grant == G_WR);
    assign buf_hit     = buf_valid && (wr_addr == buf_addr) && (wr_sel == buf_sel);
    assign wr_ready    = !rst && (!buf_valid || buf_drain || buf_hit);
    assign wr_pending  = buf_valid;
    assign wr_mem_addr = buf_addr;
    assign wr_mem_sel  = buf_sel;
    assign wr_mem_data = buf_data;

    // A new write loads the entry even while the old one drains; a hit rewrites it in place.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_sel   <= '0;
            buf_data  <= '0;
        end else if (wr_accept && wr_in_range) begin
            buf_valid <= 1'b1;
            buf_addr  <= wr_addr;
            buf_sel   <= wr_sel;
            buf_data  <= wr_data;
        end else if (buf_drain) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign wr_ready    = !rst && (state == S_IDLE) && !vid_req && !clr_start;
    assign wr_pending  = wr_accept && wr_in_range;
    assign wr_mem_addr = wr_addr;
    assign wr_mem_sel  = wr_sel;
    assign wr_mem_data = wr_data;
`endif

    fb_clear_seq u_clear_seq (
        .clk_25      (clk_25),
        .rst         (rst),
        .start       (clr_accept),
        .advance     (grant == G_CLR),
        .colour      (clr_colour),
        .word_addr   (clr_addr),
        .fill_colour (clr_fill),
        .last        (clr_last)
    );

    always_ff @(posedge clk_25) begin
        if (rst) begin
            state  <= S_IDLE;
            wr_err <= 1'b0;
        end else begin
            state  <= state_next;
            wr_err <= wr_accept && !wr_in_range;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (clr_start) state_next = S_CLEAR;
            S_CLEAR: if (clr_last)  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Video is granted purely combinationally so the fetcher sees zero latency.
    always_comb begin
        grant = G_NONE;
        if (!rst) begin
            if (vid_req)               grant = G_VID;
            else if (state == S_CLEAR) grant = G_CLR;
            else if (wr_pending)       grant = G_WR;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wall  = 1'b0;
        mem_addr  = '0;
        mem_sel   = '0;
        mem_wdata = '0;
        case (grant)
            G_VID: begin
                mem_en   = 1'b1;
                mem_addr = vid_addr;
                mem_sel  = vid_sel;
            end
            G_CLR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_wall  = 1'b1;
                mem_addr  = clr_addr;
                mem_wdata = clr_fill;
            end
            G_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_mem_addr;
                mem_sel   = wr_mem_sel;
                mem_wdata = wr_mem_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Self-checking bench for fb_mem_arbiter (default build, unbuffered host port).
module tb_fb_mem_arbiter;

    localparam int WORDS = 384;

    typedef struct packed {
        logic       rst;
        logic       vid_req;
        logic [8:0] vid_addr;
        logic [2:0] vid_sel;
        logic       wr_valid;
        logic [8:0] wr_addr;
        logic [2:0] wr_sel;
        logic [3:0] wr_data;
        logic       clr_start;
        logic [3:0] clr_colour;
        logic [3:0] mem_rdata;
    } ins_t;

    typedef struct packed {
        logic       en;
        logic       we;
        logic       wall;
        logic [8:0] addr;
        logic [2:0] sel;
        logic [3:0] wdata;
        logic [3:0] pix;
        logic       ready;
        logic       err;
        logic       busy;
        logic       done;
    } outs_t;

    typedef struct {
        string name;
        ins_t  in;
        outs_t exp;
    } vec_t;

    logic       clk_25 = 1'b0;
    logic       rst, vid_req, wr_valid, clr_start;
    logic [8:0] vid_addr, wr_addr, mem_addr;
    logic [2:0] vid_sel, wr_sel, mem_sel;
    logic [3:0] wr_data, clr_colour, mem_rdata, vid_pixel, mem_wdata;
    logic       wr_ready, wr_err, clr_busy, clr_done, mem_en, mem_we, mem_wall;

    int checks = 0;
    int failures = 0;

    // Reference model: words still to clear, one-cycle done flag, pending error flag.
    int         mClrLeft = 0;
    bit         mDone = 0;
    bit         mErr = 0;
    logic [3:0] mCol = '0;

    always #20 clk_25 = ~clk_25;

    fb_mem_arbiter dut (
        .clk_25(clk_25), .rst(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_sel(vid_sel), .vid_pixel(vid_pixel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .wr_data(wr_data), .wr_err(wr_err),
        .clr_start(clr_start), .clr_colour(clr_colour), .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wall(mem_wall), .mem_addr(mem_addr),
        .mem_sel(mem_sel), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic applyStimulus(input ins_t i);
        rst        = i.rst;
        vid_req    = i.vid_req;
        vid_addr   = i.vid_addr;
        vid_sel    = i.vid_sel;
        wr_valid   = i.wr_valid;
        wr_addr    = i.wr_addr;
        wr_sel     = i.wr_sel;
        wr_data    = i.wr_data;
        clr_start  = i.clr_start;
        clr_colour = i.clr_colour;
        mem_rdata  = i.mem_rdata;
    endtask

    function automatic outs_t sampleOutputs();
        outs_t o;
        o = '{en: mem_en, we: mem_we, wall: mem_wall, addr: mem_addr, sel: mem_sel,
              wdata: mem_wdata, pix: vid_pixel, ready: wr_ready, err: wr_err,
              busy: clr_busy, done: clr_done};
        return o;
    endfunction

    task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got en=%b we=%b wall=%b addr=%0d sel=%0d wdata=%h pix=%h ready=%b err=%b busy=%b done=%b, want en=%b we=%b wall=%b addr=%0d sel=%0d wdata=%h pix=%h ready=%b err=%b busy=%b done=%b",
                     name, act.en, act.we, act.wall, act.addr, act.sel, act.wdata, act.pix,
                     act.ready, act.err, act.busy, act.done, exp.en, exp.we, exp.wall, exp.addr,
                     exp.sel, exp.wdata, exp.pix, exp.ready, exp.err, exp.busy, exp.done);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Expected outputs for this cycle from the arbitration rules, then advance the model.
    task automatic modelCycle(input ins_t i, output outs_t e);
        bit busy, accept;
        e = '0;
        busy   = (mClrLeft > 0) || mDone;
        e.busy = busy;
        e.done = mDone;
        e.err  = mErr;
        e.pix  = i.mem_rdata;
        if (i.rst) begin
            mClrLeft = 0;
            mDone    = 0;
            mErr     = 0;
            return;
        end
        if (i.vid_req) begin
            e.en = 1; e.addr = i.vid_addr; e.sel = i.vid_sel;
        end else if (mClrLeft > 0) begin
            e.en = 1; e.we = 1; e.wall = 1; e.addr = 9'(WORDS - mClrLeft); e.wdata = mCol;
        end
        e.ready = !i.vid_req && !busy && !i.clr_start;
        accept  = e.ready && i.wr_valid;
        if (accept && i.wr_addr < WORDS) begin
            e.en = 1; e.we = 1; e.addr = i.wr_addr; e.sel = i.wr_sel; e.wdata = i.wr_data;
        end
        mErr = accept && (i.wr_addr >= WORDS);
        if (mDone) begin
            mDone = 0;
        end else if (mClrLeft > 0) begin
            if (!i.vid_req) begin
                mClrLeft--;
                if (mClrLeft == 0) mDone = 1;
            end
        end else if (i.clr_start) begin
            mClrLeft = WORDS;
            mCol     = i.clr_colour;
        end
    endtask

    // One clock: drive, settle mid-cycle, compare against the model, advance past the edge.
    task automatic modelStep(input string name, input ins_t i, output outs_t act);
        outs_t e;
        applyStimulus(i);
        modelCycle(i, e);
        #10;
        act = sampleOutputs();
        checkOutput(name, act, e);
        @(posedge clk_25);
        #1;
    endtask

    task automatic hardReset();
        ins_t z;
        z = '0;
        z.rst = 1;
        applyStimulus(z);
        repeat (2) @(posedge clk_25);
        #1;
        mClrLeft = 0; mDone = 0; mErr = 0;
    endtask

    initial begin
        vec_t  vecs[9];
        ins_t  i;
        outs_t act, e;
        int    words, orderErrs, hostWrites, lastWr, doneAt, doneCount, cyc;
        bit    hit;

        // Single-cycle vectors, applied back to back from a freshly reset idle arbiter.
        for (int k = 0; k < 9; k++) begin
            vecs[k].in = '0;
            vecs[k].exp = '0;
        end
        vecs[0].name = "idle";
        vecs[0].exp.ready = 1;
        vecs[1].name = "vid_read";
        vecs[1].in.vid_req = 1; vecs[1].in.vid_addr = 9'd17; vecs[1].in.vid_sel = 3'd3;
        vecs[1].in.mem_rdata = 4'hA;
        vecs[1].exp.en = 1; vecs[1].exp.addr = 9'd17; vecs[1].exp.sel = 3'd3; vecs[1].exp.pix = 4'hA;
        vecs[2].name = "wr_during_vid";
        vecs[2].in = vecs[1].in; vecs[2].in.mem_rdata = 4'h0;
        vecs[2].in.wr_valid = 1; vecs[2].in.wr_addr = 9'd5; vecs[2].in.wr_sel = 3'd2; vecs[2].in.wr_data = 4'h7;
        vecs[2].exp.en = 1; vecs[2].exp.addr = 9'd17; vecs[2].exp.sel = 3'd3;
        vecs[3].name = "wr_after_vid";
        vecs[3].in.wr_valid = 1; vecs[3].in.wr_addr = 9'd5; vecs[3].in.wr_sel = 3'd2; vecs[3].in.wr_data = 4'h7;
        vecs[3].exp.en = 1; vecs[3].exp.we = 1; vecs[3].exp.addr = 9'd5; vecs[3].exp.sel = 3'd2;
        vecs[3].exp.wdata = 4'h7; vecs[3].exp.ready = 1;
        vecs[4].name = "wr_oob";
        vecs[4].in.wr_valid = 1; vecs[4].in.wr_addr = 9'd400; vecs[4].in.wr_sel = 3'd1; vecs[4].in.wr_data = 4'hF;
        vecs[4].exp.ready = 1;
        vecs[5].name = "err_pulse";
        vecs[5].exp.ready = 1; vecs[5].exp.err = 1;
        vecs[6].name = "err_clear";
        vecs[6].exp.ready = 1;
        vecs[7].name = "clr_start_blocks_wr";
        vecs[7].in.clr_start = 1; vecs[7].in.clr_colour = 4'h3;
        vecs[7].in.wr_valid = 1; vecs[7].in.wr_addr = 9'd5;
        vecs[8].name = "clr_word0";
        vecs[8].exp.en = 1; vecs[8].exp.we = 1; vecs[8].exp.wall = 1; vecs[8].exp.wdata = 4'h3;
        vecs[8].exp.busy = 1;

        i = '0; i.rst = 1;
        applyStimulus(i);
        @(posedge clk_25);
        #11;
        checkOutput("reset_state", sampleOutputs(), '0);
        @(posedge clk_25);
        #1;

        for (int k = 0; k < 9; k++) begin
            applyStimulus(vecs[k].in);
            #10;
            checkOutput(vecs[k].name, sampleOutputs(), vecs[k].exp);
            @(posedge clk_25);
            #1;
        end

        // Full clear with video stealing every 10th cycle and a host write pending throughout.
        hardReset();
        i = '0; i.clr_start = 1; i.clr_colour = 4'h3; i.vid_req = 1; i.wr_valid = 1; i.wr_addr = 9'd7;
        modelStep("clr10_start", i, act);
        words = 0; orderErrs = 0; hostWrites = 0; lastWr = -1; doneAt = -1;
        for (int c = 1; c < 700 && doneAt < 0; c++) begin
            i = '0; i.vid_req = (c % 10 == 0); i.vid_addr = 9'(c); i.wr_valid = 1;
            i.wr_addr = 9'd7; i.wr_data = 4'h1; i.mem_rdata = 4'(c);
            modelStep("clr10_cycle", i, act);
            if (act.we && act.wall) begin
                if (act.addr != 9'(words)) orderErrs++;
                words++;
                lastWr = c;
            end
            if (act.we && !act.wall) hostWrites++;
            if (act.done) doneAt = c;
        end
        checkValue("clr10_words", words, WORDS);
        checkValue("clr10_order_errs", orderErrs, 0);
        checkValue("clr10_host_writes", hostWrites, 0);
        checkValue("clr10_done_latency", doneAt - lastWr, 1);

        // Reset lands on the cycle that would have written word 100.
        hardReset();
        i = '0; i.clr_start = 1; i.clr_colour = 4'h9;
        modelStep("rst100_start", i, act);
        hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            modelStep("rst100_run", '0, act);
            hit = act.wall && (act.addr == 9'd99);
        end
        checkValue("rst100_reached_99", int'(hit), 1);
        i = '0; i.rst = 1;
        modelStep("rst100_rst", i, act);
        modelStep("rst100_after", '0, act);
        checkValue("rst100_busy_dropped", int'(act.busy), 0);
        doneCount = 0;
        for (int c = 0; c < 400; c++) begin
            modelStep("rst100_quiet", '0, act);
            if (act.done) doneCount++;
        end
        checkValue("rst100_no_done", doneCount, 0);
        i = '0; i.clr_start = 1; i.clr_colour = 4'h5;
        modelStep("rst100_restart", i, act);
        modelStep("rst100_word0", '0, act);
        checkValue("rst100_restart_addr", int'(act.addr), 0);
        checkValue("rst100_restart_wall", int'(act.wall), 1);

        // Randomised traffic against the model, including mid-run resets.
        hardReset();
        cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            i = '0;
            i.rst        = ($urandom_range(0, 499) == 0);
            i.vid_req    = ($urandom_range(0, 2) == 0);
            i.vid_addr   = 9'($urandom_range(0, WORDS - 1));
            i.vid_sel    = 3'($urandom);
            i.wr_valid   = ($urandom_range(0, 1) == 1);
            i.wr_addr    = 9'($urandom_range(0, 511));
            i.wr_sel     = 3'($urandom);
            i.wr_data    = 4'($urandom);
            i.clr_start  = ($urandom_range(0, 63) == 0);
            i.clr_colour = 4'($urandom);
            i.mem_rdata  = 4'($urandom);
            modelStep("random", i, act);
            if (act.we && !act.wall) cyc++;
        end
        checkValue("random_saw_host_writes", int'(cyc > 0), 1);

        i = '0;
        modelCycle(i, e);
        applyStimulus(i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
